delay_mix_engine: RTL and testbench
===================================

Name: delay_mix_engine

Overview:
- Parametrised N-tap delay/chorus mixer, the next generation of the fixed delay + three-chorus path in the FPGA effects top level.
- Takes one gated, offset-corrected signed sample per sample strobe and stores it in an internal circular buffer.
- Sums the dry sample with NUM_TAPS delayed copies, each with its own delay and gain, then saturates and emits the result.
- Sits between offset removal and the overdrive/Pi SPI stage.

Parameters:
- WIDTH, 11: signed two's-complement sample width.
- ADDR_W, 13: buffer address width; depth = 2^ADDR_W samples.
- NUM_TAPS, 4: number of delay taps.
- GAIN_W, 4: per-tap unsigned gain width; gain 2^(GAIN_W-1) = unity.
- GATE_THRESH, 7: dry samples with |x| < GATE_THRESH are forced to 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe; sample_in is valid.
- sample_in  in  WIDTH  signed input sample.
- tap_en  in  NUM_TAPS  per-tap enable.
- tap_delay  in  NUM_TAPS*ADDR_W  per-tap delay in samples; tap k is at [k*ADDR_W +: ADDR_W].
- tap_gain  in  NUM_TAPS*GAIN_W  per-tap gain; tap k is at [k*GAIN_W +: GAIN_W].
- busy  out  1  engine is processing; new strobes are dropped.
- out_valid  out  1  one-cycle pulse; out_sample is valid.
- out_sample  out  WIDTH  signed mixed, saturated sample.
- out_clip  out  1  saturation occurred on this output; valid with out_valid.
- overrun  out  1  one-cycle pulse; a strobe was dropped.

Behaviour:
- Reset state: busy, out_valid, out_clip and overrun are 0; out_sample is 0; wr_ptr and fill are 0; state is IDLE.
- Buffer RAM contents are not cleared by reset.
- Reset mid-operation aborts the sample: no RAM write occurs and no out_valid is produced.
- FSM: IDLE -> GATE -> TAP (NUM_TAPS cycles) -> SAT -> IDLE.
- IDLE, sample_valid=1 (cycle 0): latch sample_in, tap_en, tap_delay and tap_gain. Config changes after accept do not affect that sample.
- GATE (cycle 1): dry = (|x| < GATE_THRESH) ? 0 : x; acc = sign-extended dry; issue RAM read address for tap 0.
- TAP (cycles 2..NUM_TAPS+1): RAM has 1-cycle read latency. Each cycle adds tap k's contribution and issues the address for tap k+1.
- Tap read address = (wr_ptr - delay) mod 2^ADDR_W.
- A tap contributes 0 if any of these holds: tap_en[k] = 0; delay = 0; delay > fill.
- fill is a saturating count of samples written since reset, capped at 2^ADDR_W - 1. This prevents stale RAM from contributing after reset.
- Contribution = (tap * gain) >>> (GAIN_W-1): arithmetic shift, rounds toward negative infinity.
- Accumulator width is WIDTH + GAIN_W + clog2(NUM_TAPS+1); it never overflows internally.
- SAT (cycle NUM_TAPS+2): clamp acc to the symmetric range ±(2^(WIDTH-1)-1). The most-negative code is never emitted, which keeps the output sign-magnitude safe for the Pi. Set the clip flag if clamping occurred.
- SAT also writes the RAM word at wr_ptr, then wr_ptr <= wr_ptr + 1 with natural wrap at 2^ADDR_W, and fill increments (saturating).
- Output timing: out_valid pulses in cycle NUM_TAPS+3, with out_sample and out_clip registered and held until the next out_valid. State is IDLE in that same cycle.
- busy = (state != IDLE), i.e. high for cycles 1..NUM_TAPS+2.
- Minimum strobe spacing is NUM_TAPS+3 cycles.
- A strobe while busy is dropped and overrun pulses the following cycle.
- A strobe in the same cycle that out_valid pulses is accepted, since state is already IDLE.

Optional Feature:
- Macro FEEDBACK_EN.
- Defined: SAT writes the saturated mix back into the buffer instead of dry, giving regenerative echo.
- Undefined: SAT writes the gated dry sample, giving feed-forward only.
- In both cases, output behaviour and timing are otherwise identical.

Test Plan:
All tests use default parameters unless stated.
1. Reset, all taps disabled, sample 100 -> out_valid exactly 7 cycles after the strobe cycle, out_sample=100, out_clip=0, busy high for 6 cycles.
2. Gate: sample 5 -> out 0; sample -7 -> out -7; sample 6 then tap0 delay 1 gain 8 on the next sample 0 -> out 0 (stored value was gated to 0).
3. Tap0 en, delay 3, gain 8; feed 100,0,0,0 -> outputs 100,0,0,100. Repeat with gain 4 -> 4th output 50. Tap0 delay 3 on the 2nd sample after reset (fill=1) -> contribution 0.
4. Saturation: taps 0..3 delays 1..4, all gain 15, constant 1000 -> steady out 1023, clip=1. Constant -1000 -> -1023, clip=1.
5. Overrun: strobes 2 cycles apart -> single out_valid, overrun pulse 1 cycle after the 2nd strobe; strobe in the out_valid cycle -> accepted, no overrun.
6. Wrap/reset: ramp 8200 samples with tap0 delay 1 gain 8 -> out[i] = ramp[i] + ramp[i-1] across the wr_ptr wrap. Assert reset at cycle 3 of a sample -> no out_valid, and the next sample with delay 1 contributes 0. With FEEDBACK_EN, tap0 delay 1 gain 4 and impulse 64 -> outputs 64,32,16,8.

Source files
------------

// File: rtl/delay_mix_engine.sv
// delay_mix_engine: N-tap delay/chorus mixer with gated dry path and symmetric output saturation.
// Build macro FEEDBACK_EN: the saturated mix (not the gated dry sample) is written to the delay line.
//
// state | meaning
// IDLE  | waiting for sample_valid; out_valid pulses here
// GATE  | noise gate on latched sample, read address for tap 0
// TAP   | accumulate one tap per cycle, read address for next tap
// SAT   | clamp, write delay line, advance wrPtr and fill
module delay_mix_engine #(
  parameter int WIDTH       = 11,
  parameter int ADDR_W      = 13,
  parameter int NUM_TAPS    = 4,
  parameter int GAIN_W      = 4,
  parameter int GATE_THRESH = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic signed [WIDTH-1:0]      sample_in,
  input  logic [NUM_TAPS-1:0]          tap_en,
  input  logic [NUM_TAPS*ADDR_W-1:0]   tap_delay,
  input  logic [NUM_TAPS*GAIN_W-1:0]   tap_gain,
  output logic                         busy,
  output logic                         out_valid,
  output logic signed [WIDTH-1:0]      out_sample,
  output logic                         out_clip,
  output logic                         overrun
);

  localparam int TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int ACC_W  = WIDTH + GAIN_W + $clog2(NUM_TAPS + 1);
  localparam int PROD_W = WIDTH + GAIN_W + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX;
  localparam logic signed [WIDTH-1:0] GATE_POS = WIDTH'(GATE_THRESH);
  localparam logic signed [WIDTH-1:0] GATE_NEG = -GATE_POS;
  localparam logic [ADDR_W-1:0] FILL_MAX = '1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {IDLE, GATE, TAP, SAT} stateT;
  stateT state, nextState;

  logic [WIDTH-1:0] mem [0:(1 << ADDR_W)-1];
  logic signed [WIDTH-1:0] sampleLat, dryNext, rdData, satVal, wrData;
  logic [NUM_TAPS-1:0] enLat;
  logic [ADDR_W-1:0] delayLat [NUM_TAPS];
  logic [GAIN_W-1:0] gainLat [NUM_TAPS];
  logic [ADDR_W-1:0] wrPtr, fill, rdAddr;
  logic [TAP_W-1:0] tapIdx, rdIdx;
  logic signed [ACC_W-1:0] acc, contrib;
  logic signed [PROD_W-1:0] prod;
  logic tapLive, satClip, ramWe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (sample_valid) nextState = GATE;
      GATE:    nextState = TAP;
      TAP:     if (tapIdx == LAST_TAP) nextState = SAT;
      SAT:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    dryNext = ((sampleLat > GATE_NEG) && (sampleLat < GATE_POS)) ? '0 : sampleLat;
    rdIdx   = (state == GATE) ? '0 : tapIdx + TAP_W'(1);
    rdAddr  = wrPtr - delayLat[rdIdx];
    // Taps reaching past what has been written since reset would read stale RAM.
    tapLive = enLat[tapIdx] && (delayLat[tapIdx] != '0) && (delayLat[tapIdx] <= fill);
    prod    = PROD_W'(rdData) * PROD_W'($signed({1'b0, gainLat[tapIdx]}));
    contrib = tapLive ? ACC_W'(prod >>> (GAIN_W - 1)) : '0;
    satClip = 1'b0;
    if (acc > SAT_MAX) begin
      satVal  = SAT_MAX[WIDTH-1:0];
      satClip = 1'b1;
    end else if (acc < SAT_MIN) begin
      satVal  = SAT_MIN[WIDTH-1:0];
      satClip = 1'b1;
    end else begin
      satVal = acc[WIDTH-1:0];
    end
    ramWe = (state == SAT);
`ifdef FEEDBACK_EN
    wrData = satVal;
`else
    wrData = sampleLat;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sampleLat  <= '0;
      enLat      <= '0;
      acc        <= '0;
      tapIdx     <= '0;
      wrPtr      <= '0;
      fill       <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_clip   <= 1'b0;
      overrun    <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        delayLat[k] <= '0;
        gainLat[k]  <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      overrun   <= sample_valid && (state != IDLE);
      case (state)
        IDLE: if (sample_valid) begin
          sampleLat <= sample_in;
          enLat     <= tap_en;
          for (int k = 0; k < NUM_TAPS; k++) begin
            delayLat[k] <= tap_delay[k*ADDR_W +: ADDR_W];
            gainLat[k]  <= tap_gain[k*GAIN_W +: GAIN_W];
          end
        end
        GATE: begin
          // sampleLat now holds the gated dry value, which is what gets stored.
          sampleLat <= dryNext;
          acc       <= ACC_W'(dryNext);
          tapIdx    <= '0;
        end
        TAP: begin
          acc    <= acc + contrib;
          tapIdx <= tapIdx + TAP_W'(1);
        end
        SAT: begin
          wrPtr      <= wrPtr + ADDR_W'(1);
          if (fill != FILL_MAX) fill <= fill + ADDR_W'(1);
          out_valid  <= 1'b1;
          out_sample <= satVal;
          out_clip   <= satClip;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ramWe) mem[wrPtr] <= wrData;
    rdData <= mem[rdAddr];
  end

endmodule

// File: tb/tb_delay_mix_engine.sv
// tb_delay_mix_engine: directed self-checking bench for delay_mix_engine with default parameters.
module tb_delay_mix_engine;

  logic clk;
  logic reset;
  logic sample_valid;
  logic signed [10:0] sample_in;
  logic [3:0] tap_en;
  logic [51:0] tap_delay;
  logic [15:0] tap_gain;
  logic busy;
  logic out_valid;
  logic signed [10:0] out_sample;
  logic out_clip;
  logic overrun;

  int passCnt = 0;
  int total = 0;

  delay_mix_engine dut (
    .clk(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .sample_in(sample_in),
    .tap_en(tap_en),
    .tap_delay(tap_delay),
    .tap_gain(tap_gain),
    .busy(busy),
    .out_valid(out_valid),
    .out_sample(out_sample),
    .out_clip(out_clip),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passCnt, total);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int gateOf(input int v);
    return (v > -7 && v < 7) ? 0 : v;
  endfunction

  task automatic resetDut();
    reset = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clearTaps();
    tap_en = '0;
    tap_delay = '0;
    tap_gain = '0;
  endtask

  task automatic setTap(input int k, input logic en, input int dly, input int gain);
    tap_en[k] = en;
    tap_delay[k*13 +: 13] = 13'(dly);
    tap_gain[k*4 +: 4] = 4'(gain);
  endtask

  // Called at a negedge; returns at the negedge where out_valid is seen (or after the bound).
  task automatic runSample(input int x, output int obsOut, output int obsClip,
                           output int lat, output int busyCyc);
    bit seen = 1'b0;
    lat = 0;
    busyCyc = 0;
    obsOut = 0;
    obsClip = 0;
    sample_in = 11'(x);
    sample_valid = 1'b1;
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      sample_valid = 1'b0;
      if (busy) busyCyc++;
      if (out_valid) begin
        seen = 1'b1;
        obsOut = int'(out_sample);
        obsClip = int'(out_clip);
      end
    end
    if (!seen) lat = 99;
  endtask

  task automatic mix(input int x, input int expOut, input int expClip, input string tag);
    int o, c, l, b;
    runSample(x, o, c, l, b);
    chk({tag, "_lat"}, l, 7);
    chk({tag, "_out"}, o, expOut);
    chk({tag, "_clip"}, c, expClip);
  endtask

  initial begin
    int o, c, l, b;
    int prev, x, expv;
    int earlyOv, ovCnt, pulses, pulseCyc, pulseVal, busyAt8, lateValid;
    int fbExp [4];

    reset = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    clearTaps();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_out_clip", out_clip, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic pass-through and timing
    runSample(100, o, c, l, b);
    chk("t1_latency", l, 7);
    chk("t1_busy_cycles", b, 6);
    chk("t1_out", o, 100);
    chk("t1_clip", c, 0);

    // Noise gate
    mix(5, 0, 0, "gate_small");
    mix(-7, -7, 0, "gate_edge_neg");
    mix(7, 7, 0, "gate_edge_pos");
    mix(6, 0, 0, "gate_six");
    setTap(0, 1'b1, 1, 8);
    mix(0, 0, 0, "gate_stored");

    // Single tap, unity and half gain
    resetDut();
    clearTaps();
    setTap(0, 1'b1, 3, 8);
    mix(100, 100, 0, "d3g8_0");
    mix(0, 0, 0, "d3g8_1");
    mix(0, 0, 0, "d3g8_2");
    mix(0, 100, 0, "d3g8_3");
    resetDut();
    setTap(0, 1'b1, 3, 4);
    mix(100, 100, 0, "d3g4_0");
    mix(0, 0, 0, "d3g4_1");
    mix(0, 0, 0, "d3g4_2");
    mix(0, 50, 0, "d3g4_3");

    // Arithmetic shift rounds toward negative infinity
    resetDut();
    setTap(0, 1'b1, 1, 3);
    mix(-100, -100, 0, "floor_a");
    mix(0, -38, 0, "floor_neg");
    mix(100, 100, 0, "floor_b");
    mix(0, 37, 0, "floor_pos");

    // Saturation boundaries
    resetDut();
    clearTaps();
    mix(1023, 1023, 0, "sat_max_exact");
    mix(-1023, -1023, 0, "sat_min_exact");
    mix(-1024, -1023, 1, "sat_most_neg");
    for (int k = 0; k < 4; k++) setTap(k, 1'b1, k + 1, 15);
    for (int i = 0; i < 6; i++) runSample(1000, o, c, l, b);
    chk("sat_pos_out", o, 1023);
    chk("sat_pos_clip", c, 1);
    for (int i = 0; i < 6; i++) runSample(-1000, o, c, l, b);
    chk("sat_neg_out", o, -1023);
    chk("sat_neg_clip", c, 1);

    // Overrun and back-to-back acceptance
    clearTaps();
    sample_in = 11'sd200;
    sample_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    sample_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    sample_in = -11'sd300;
    sample_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    sample_valid = 1'b0;
    chk("ovr_pulse", overrun, 1);
    earlyOv = 0;
    ovCnt = 0;
    for (int cyc = 4; cyc <= 7; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (overrun) ovCnt++;
      if (cyc < 7 && out_valid) earlyOv++;
    end
    chk("ovr_no_early_out", earlyOv, 0);
    chk("ovr_first_valid", out_valid, 1);
    chk("ovr_first_out", out_sample, 200);
    sample_in = -11'sd50;
    sample_valid = 1'b1;
    pulses = 0;
    pulseCyc = 0;
    pulseVal = 0;
    busyAt8 = 0;
    for (int cyc = 8; cyc <= 20; cyc++) begin
      @(posedge clk); @(negedge clk);
      sample_valid = 1'b0;
      if (cyc == 8) busyAt8 = busy;
      if (overrun) ovCnt++;
      if (out_valid) begin
        pulses++;
        pulseCyc = cyc;
        pulseVal = out_sample;
      end
    end
    chk("ovr_accept_busy", busyAt8, 1);
    chk("ovr_pulses", pulses, 1);
    chk("ovr_pulse_cycle", pulseCyc, 14);
    chk("ovr_second_out", pulseVal, -50);
    chk("ovr_no_spurious", ovCnt, 0);

    // Ramp across the write-pointer wrap
    resetDut();
    clearTaps();
    setTap(0, 1'b1, 1, 8);
    prev = 0;
    for (int i = 0; i < 8200; i++) begin
      x = (i % 500) - 250;
      expv = gateOf(x) + ((i > 0) ? gateOf(prev) : 0);
      runSample(x, o, c, l, b);
      chk($sformatf("ramp_%0d", i), o, expv);
      prev = x;
    end

    // Reset mid-sample aborts it; stale RAM ignored afterwards
    sample_in = 11'sd400;
    sample_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    sample_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    lateValid = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) lateValid++;
    end
    chk("midrst_no_valid", lateValid, 0);
    mix(300, 300, 0, "midrst_stale");
    setTap(0, 1'b1, 3, 8);
    mix(0, 0, 0, "fill_limit");

    // Impulse response: feed-forward vs regenerative
    resetDut();
    clearTaps();
    setTap(0, 1'b1, 1, 4);
`ifdef FEEDBACK_EN
    fbExp = '{64, 32, 16, 8};
`else
    fbExp = '{64, 32, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      runSample((i == 0) ? 64 : 0, o, c, l, b);
      chk($sformatf("impulse_%0d", i), o, fbExp[i]);
    end

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

endmodule
